gate_window_sequencer: RTL and testbench
========================================

// Module: gate_window_sequencer
// PURPOSE
//  Upstream companion of the bit-bus gate stage. It produces the data bus I_OUT and the
//  single-bit gate control CTRL, cycle-aligned, for the gate's I and CTRL inputs.
//  On TRIG it waits DLY cycles, then opens a window of LEN cycles (CTRL=1), then a
//  holdoff period. Data is captured on D_VALID and held stable for the gate.
// PARAMETERS
//  C_WIDTH      16  width of D_IN / I_OUT
//  C_DLY_WIDTH   8  width of DLY (delay count)
//  C_LEN_WIDTH   8  width of LEN (window length)
//  C_HOLDOFF     2  idle cycles forced after window closes (0 allowed)
//  C_RETRIGGER   0  1: TRIG while OPEN reloads length counter with current LEN
// PORTS
//  CLK      in   1            rising-edge clock
//  ACLR_N   in   1            asynchronous reset, active low
//  CE       in   1            clock enable; 0 freezes all state and registers
//  TRIG     in   1            start request, level sampled each enabled edge
//  DLY      in   C_DLY_WIDTH  delay before window, sampled with accepted TRIG
//  LEN      in   C_LEN_WIDTH  window length, sampled with accepted TRIG
//  D_IN     in   C_WIDTH      data to be gated
//  D_VALID  in   1            capture D_IN into I_OUT register
//  I_OUT    out  C_WIDTH      registered data -> gate I
//  CTRL     out  1            registered window -> gate CTRL
//  BUSY     out  1            state != IDLE
//  DONE     out  1            one-cycle pulse on return to IDLE
//  OVERRUN  out  1            one-cycle pulse: TRIG while busy was ignored
// BEHAVIOUR
//  Reset (ACLR_N=0, async): state=IDLE, I_OUT=0, CTRL=0, BUSY=0, DONE=0, OVERRUN=0,
//   counters=0. Release is synchronised by the reset tree, not in this block.
//  All registers update only on edges with CE=1. Pulses stay 0 on CE=0 edges.
//  FSM: IDLE, DELAY, OPEN, HOLD. One down-counter shared by all states.
//   IDLE : TRIG=1 -> latch DLY/LEN; LEN=0 -> DONE pulse, stay IDLE, CTRL never rises;
//          DLY=0 -> OPEN with cnt=LEN-1; else DELAY with cnt=DLY-1.
//   DELAY: cnt==0 -> OPEN with cnt=LEN_latched-1; else cnt--.
//   OPEN : cnt==0 -> HOLD with cnt=C_HOLDOFF-1 (C_HOLDOFF=0 -> IDLE + DONE); else cnt--.
//   HOLD : cnt==0 -> IDLE, DONE=1 for one cycle; else cnt--.
//  CTRL is registered as (next_state==OPEN). TRIG accepted at edge k with DLY=d, LEN=n:
//   CTRL=1 after edges k+d .. k+d+n-1, 0 after edge k+d+n. DONE=1 after edge
//   k+d+n+C_HOLDOFF. Next TRIG is accepted no earlier than that same edge (DONE cycle).
//  TRIG in DELAY/HOLD, or in OPEN with C_RETRIGGER=0: ignored, OVERRUN=1 next cycle.
//  TRIG in OPEN with C_RETRIGGER=1: cnt=LEN-1 (new LEN, LEN=0 treated as 1), no OVERRUN.
//  I_OUT: D_VALID=1 at an enabled edge -> I_OUT=D_IN after that edge; else hold.
//   Capture is independent of state, giving 1-cycle latency, aligned with CTRL.
//  Counter widths: max(C_DLY_WIDTH, C_LEN_WIDTH, clog2(C_HOLDOFF+1)). Never wraps:
//   decrement only when nonzero.
//  Reset asserted mid-window: CTRL drops immediately (async), no DONE is generated.
// STRUCTURE
//  Shared package gws_pkg: state encoding localparams (IDLE=0, DELAY=1, OPEN=2, HOLD=3),
//   gate-type constants (and/nand/or/nor/xor/xnor = 0..5) shared with the gate stage.
//  One sub-module: gws_down_counter (load, dec, zero flag, CE, ACLR_N), param width.
//  Top level instantiates the FSM and I_OUT register, and drives the gate stage.
// TESTING
//  1 Reset: ACLR_N=0 mid-OPEN -> CTRL/BUSY/I_OUT=0 same cycle, no DONE after release.
//  2 TRIG edge 10, DLY=3, LEN=4, HOLDOFF=2 -> CTRL=1 after edges 13..16, DONE after 19.
//  3 DLY=0, LEN=1 -> CTRL high exactly one cycle after TRIG edge; LEN=0 -> DONE next
//    cycle, CTRL stays 0.
//  4 TRIG during DELAY (C_RETRIGGER=0) -> OVERRUN one cycle, window timing unchanged.
//  5 C_RETRIGGER=1, TRIG at 2nd OPEN cycle with LEN=5 -> CTRL stays high 5 more cycles.
//  6 CE=0 for 3 cycles inside OPEN -> window extended by 3; D_VALID ignored during
//    those cycles. D_VALID with D_IN=16'hA5C3 -> I_OUT=16'hA5C3 next cycle.

Source files
------------

// File: rtl/gws_pkg.sv
// Shared definitions for the gate window sequencer and its gate stage.
// State encoding, gate-type codes and a width helper.
package gws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } gws_state_e;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_NAND = 3'd1;
  localparam logic [2:0] GATE_OR   = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  function automatic int gws_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gws_down_counter.sv
// Loadable down-counter that saturates at zero.
// Load wins over decrement; all updates are gated by CE.
module gws_down_counter
  import gws_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         ACLR_N,
  input  logic         CE,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      cnt_q <= '0;
    end else if (CE) begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_window_sequencer.sv
// Delay / window / holdoff sequencer feeding the bit-bus gate stage.
// Produces registered I_OUT data and CTRL window, cycle-aligned.
module gate_window_sequencer
  import gws_pkg::*;
#(
  parameter int C_WIDTH     = 16,
  parameter int C_DLY_WIDTH = 8,
  parameter int C_LEN_WIDTH = 8,
  parameter int C_HOLDOFF   = 2,
  parameter int C_RETRIGGER = 0
) (
  input  logic                   CLK,
  input  logic                   ACLR_N,
  input  logic                   CE,
  input  logic                   TRIG,
  input  logic [C_DLY_WIDTH-1:0] DLY,
  input  logic [C_LEN_WIDTH-1:0] LEN,
  input  logic [C_WIDTH-1:0]     D_IN,
  input  logic                   D_VALID,
  output logic [C_WIDTH-1:0]     I_OUT,
  output logic                   CTRL,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   OVERRUN
);

  localparam int CNT_W = gws_max3(C_DLY_WIDTH, C_LEN_WIDTH,
                                  $clog2(C_HOLDOFF + 1));
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'((C_HOLDOFF > 0) ? C_HOLDOFF - 1 : 0);

  gws_state_e             state_q, state_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [C_WIDTH-1:0]     i_out_q, i_out_d;
  logic                   ctrl_q, ctrl_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  gws_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .ACLR_N   (ACLR_N),
    .CE       (CE),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      i_out_q   <= '0;
      ctrl_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      len_q     <= len_d;
      i_out_q   <= i_out_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (TRIG) begin
          len_d = LEN;
          if (LEN == '0) begin
            state_d = ST_IDLE;
          end else if (DLY == '0) begin
            state_d    = ST_OPEN;
            cnt_load   = 1'b1;
            cnt_ld_val = CNT_W'(LEN) - CNT_W'(1);
          end else begin
            state_d    = ST_DELAY;
            cnt_load   = 1'b1;
            cnt_ld_val = CNT_W'(DLY) - CNT_W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (cnt_zero) begin
          state_d    = ST_OPEN;
          cnt_load   = 1'b1;
          cnt_ld_val = CNT_W'(len_q) - CNT_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_OPEN: begin
        // A retrigger of length 0 still keeps the window open one cycle
        if ((C_RETRIGGER != 0) && TRIG) begin
          len_d      = LEN;
          cnt_load   = 1'b1;
          cnt_ld_val = (LEN == '0) ? '0 : CNT_W'(LEN) - CNT_W'(1);
        end else if (cnt_zero) begin
          if (C_HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_HOLD;
            cnt_load   = 1'b1;
            cnt_ld_val = HOLD_LD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d    = (state_d == ST_OPEN);
    done_d    = (state_d == ST_IDLE) &&
                ((state_q != ST_IDLE) || TRIG);
    overrun_d = TRIG &&
                ((state_q == ST_DELAY) || (state_q == ST_HOLD) ||
                 ((state_q == ST_OPEN) && (C_RETRIGGER == 0)));
    i_out_d   = D_VALID ? D_IN : i_out_q;
  end

  assign I_OUT   = i_out_q;
  assign CTRL    = ctrl_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_gate_window_sequencer.sv
// Directed bench for gate_window_sequencer.
// Two instances: no-retrigger and retrigger, sharing stimulus.
module tb_gate_window_sequencer;

  logic        clk;
  logic        aclr_n;
  logic        ce;
  logic        trig;
  logic [7:0]  dly;
  logic [7:0]  len;
  logic [15:0] d_in;
  logic        d_valid;

  logic [15:0] i_out, i_out_r;
  logic        ctrl, ctrl_r;
  logic        busy, busy_r;
  logic        done, done_r;
  logic        overrun, overrun_r;

  int checks = 0;
  int passed = 0;

  gate_window_sequencer #(
    .C_WIDTH (16), .C_DLY_WIDTH (8), .C_LEN_WIDTH (8),
    .C_HOLDOFF (2), .C_RETRIGGER (0)
  ) dut (
    .CLK (clk), .ACLR_N (aclr_n), .CE (ce), .TRIG (trig),
    .DLY (dly), .LEN (len), .D_IN (d_in), .D_VALID (d_valid),
    .I_OUT (i_out), .CTRL (ctrl), .BUSY (busy),
    .DONE (done), .OVERRUN (overrun)
  );

  gate_window_sequencer #(
    .C_WIDTH (16), .C_DLY_WIDTH (8), .C_LEN_WIDTH (8),
    .C_HOLDOFF (2), .C_RETRIGGER (1)
  ) dut_r (
    .CLK (clk), .ACLR_N (aclr_n), .CE (ce), .TRIG (trig),
    .DLY (dly), .LEN (len), .D_IN (d_in), .D_VALID (d_valid),
    .I_OUT (i_out_r), .CTRL (ctrl_r), .BUSY (busy_r),
    .DONE (done_r), .OVERRUN (overrun_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    trig    = 1'b0;
    d_valid = 1'b0;
    ce      = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset;
    aclr_n = 1'b0; ce = 1'b1; trig = 1'b0;
    dly = '0; len = '0; d_in = '0; d_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({i_out, ctrl, busy, done, overrun} !== 20'h0)
      $display("FAIL reset_state got %h want 0",
               {i_out, ctrl, busy, done, overrun});
    else passed++;
    aclr_n = 1'b1;
    tick();
    d_valid = 1'b1; d_in = 16'h5A5A;
    trig = 1'b1; dly = 8'd0; len = 8'd8;
    tick();
    trig = 1'b0; d_valid = 1'b0;
    tick(); tick();
    checks++;
    if (ctrl !== 1'b1 || i_out !== 16'h5A5A)
      $display("FAIL pre_reset_open ctrl=%b i_out=%h want 1 5a5a",
               ctrl, i_out);
    else passed++;
    #2 aclr_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 1'b0 || busy !== 1'b0 || i_out !== 16'h0)
      $display("FAIL async_reset ctrl=%b busy=%b i_out=%h want 0 0 0",
               ctrl, busy, i_out);
    else passed++;
    tick();
    aclr_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (done !== 1'b0 || ctrl !== 1'b0)
        $display("FAIL no_done_after_reset e=%0d done=%b ctrl=%b want 0 0",
                 e, done, ctrl);
      else passed++;
    end
  endtask

  task automatic test_delay_window;
    trig = 1'b1; dly = 8'd3; len = 8'd4;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 0) trig = 1'b0;
      checks++;
      if (ctrl !== (e >= 3 && e <= 6) || done !== (e == 9) ||
          busy !== (e < 9) || overrun !== 1'b0)
        $display("FAIL delay_window e=%0d ctrl=%b done=%b busy=%b ovr=%b want %b %b %b 0",
                 e, ctrl, done, busy, overrun,
                 (e >= 3 && e <= 6), (e == 9), (e < 9));
      else passed++;
    end
  endtask

  task automatic test_short_windows;
    trig = 1'b1; dly = 8'd0; len = 8'd1;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (e == 0) trig = 1'b0;
      checks++;
      if (ctrl !== (e == 0) || done !== (e == 3))
        $display("FAIL len1_window e=%0d ctrl=%b done=%b want %b %b",
                 e, ctrl, done, (e == 0), (e == 3));
      else passed++;
    end
    trig = 1'b1; dly = 8'd5; len = 8'd0;
    tick();
    trig = 1'b0;
    checks++;
    if (done !== 1'b1 || ctrl !== 1'b0 || busy !== 1'b0)
      $display("FAIL len0_done done=%b ctrl=%b busy=%b want 1 0 0",
               done, ctrl, busy);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b0 || ctrl !== 1'b0)
      $display("FAIL len0_after done=%b ctrl=%b want 0 0", done, ctrl);
    else passed++;
  endtask

  task automatic test_overrun;
    trig = 1'b1; dly = 8'd3; len = 8'd4;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 0) begin trig = 1'b1; dly = 8'd0; len = 8'd1; end
      if (e == 1) trig = 1'b0;
      checks++;
      if (overrun !== (e == 1) || ctrl !== (e >= 3 && e <= 6) ||
          done !== (e == 9))
        $display("FAIL overrun e=%0d ovr=%b ctrl=%b done=%b want %b %b %b",
                 e, overrun, ctrl, done,
                 (e == 1), (e >= 3 && e <= 6), (e == 9));
      else passed++;
    end
  endtask

  task automatic test_retrigger;
    trig = 1'b1; dly = 8'd0; len = 8'd4;
    for (int e = 0; e < 11; e++) begin
      tick();
      if (e == 0) trig = 1'b0;
      if (e == 1) begin trig = 1'b1; len = 8'd5; end
      if (e == 2) trig = 1'b0;
      checks++;
      if (ctrl_r !== (e <= 6) || done_r !== (e == 9) ||
          overrun_r !== 1'b0)
        $display("FAIL retrig_on e=%0d ctrl=%b done=%b ovr=%b want %b %b 0",
                 e, ctrl_r, done_r, overrun_r, (e <= 6), (e == 9));
      else passed++;
      checks++;
      if (ctrl !== (e <= 3) || done !== (e == 6) ||
          overrun !== (e == 2))
        $display("FAIL retrig_off e=%0d ctrl=%b done=%b ovr=%b want %b %b %b",
                 e, ctrl, done, overrun, (e <= 3), (e == 6), (e == 2));
      else passed++;
    end
  endtask

  task automatic test_clock_enable;
    trig = 1'b1; dly = 8'd0; len = 8'd4;
    d_valid = 1'b1; d_in = 16'h1111;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 0) begin trig = 1'b0; d_valid = 1'b0; end
      if (e == 1) begin ce = 1'b0; d_valid = 1'b1; d_in = 16'hFFFF; end
      if (e == 4) begin ce = 1'b1; d_in = 16'hA5C3; end
      if (e == 5) d_valid = 1'b0;
      checks++;
      if (ctrl !== (e <= 6) || done !== (e == 9) || busy !== (e < 9))
        $display("FAIL ce_window e=%0d ctrl=%b done=%b busy=%b want %b %b %b",
                 e, ctrl, done, busy, (e <= 6), (e == 9), (e < 9));
      else passed++;
      checks++;
      if (i_out !== ((e < 5) ? 16'h1111 : 16'hA5C3))
        $display("FAIL ce_i_out e=%0d got %h want %h",
                 e, i_out, (e < 5) ? 16'h1111 : 16'hA5C3);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    settle();
    test_delay_window();
    settle();
    test_short_windows();
    settle();
    test_overrun();
    settle();
    test_retrigger();
    settle();
    test_clock_enable();
    settle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
